// File: rtl/sprite_palette_bank.sv
// Multi-bank writable colour palette: index -> 12-bit RGB through a two-stage
// registered pipeline, with transparent-index reporting and a frame-timed hit flash.
module sprite_palette_bank #(
    parameter int unsigned INDEX_W         = 4,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned FLASH_FRAMES    = 8,
    localparam int unsigned BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               px_valid,
    input  logic [BANK_W-1:0]  px_bank,
    input  logic [INDEX_W-1:0] px_index,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [11:0]        wr_rgb,
    input  logic               flash_start,
    input  logic               frame_tick,
    output logic               out_valid,
    output logic               out_transparent,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               flash_active
);

    localparam int unsigned DEPTH = 1 << INDEX_W;
    localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned RGB_W = 12;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    logic [RGB_W-1:0]   pal_q [NUM_BANKS][DEPTH];

    logic               s1_valid;
    logic [BANK_W-1:0]  s1_bank;
    logic [INDEX_W-1:0] s1_index;

    logic               wr_ok;
    logic               s1_bank_ok;
    logic               s1_transp;
    logic [RGB_W-1:0]   rd_rgb;

    logic               valid_nxt;
    logic               transp_nxt;
    logic [RGB_W-1:0]   rgb_nxt;
    logic [RGB_W-1:0]   rgb_q;

    flash_state_t       state;
    flash_state_t       state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    assign wr_ok      = 32'(wr_bank) < NUM_BANKS;
    assign s1_bank_ok = 32'(s1_bank) < NUM_BANKS;
    assign s1_transp  = !s1_bank_ok || (s1_index == INDEX_W'(TRANSPARENT_IDX));

    // Palette storage; writes to a bank that does not exist are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pal_q[b][i] <= '0;
                end
            end
        end else if (wr_en && wr_ok) begin
            pal_q[wr_bank][wr_index] <= wr_rgb;
        end
    end

    // Stage 1: capture the lookup request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            s1_index <= '0;
        end else begin
            s1_valid <= px_valid;
            s1_bank  <= px_bank;
            s1_index <= px_index;
        end
    end

    // Table read sees every write up to and including the edge that sampled the request.
    always_comb begin
        rd_rgb = '0;
        if (s1_bank_ok) begin
            rd_rgb = pal_q[s1_bank][s1_index];
        end
    end

    // Stage 2 colour selection: transparency beats flash, flash beats table.
    always_comb begin
        valid_nxt  = 1'b0;
        transp_nxt = 1'b0;
        rgb_nxt    = '0;
        if (s1_valid) begin
            valid_nxt = 1'b1;
            if (s1_transp) begin
                transp_nxt = 1'b1;
            end else if (cnt != '0) begin
                rgb_nxt = {RGB_W{1'b1}};
            end else begin
                rgb_nxt = rd_rgb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_transparent <= 1'b0;
            rgb_q           <= '0;
        end else begin
            out_valid       <= valid_nxt;
            out_transparent <= transp_nxt;
            rgb_q           <= rgb_nxt;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

    // Flash controller state and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new hit restarts the full flash even if one is already running.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flash_start) begin
            state_nxt = FLASH;
            cnt_nxt   = CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && (cnt != '0)) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_nxt = IDLE;
            end
        end
    end

    assign flash_active = (state == FLASH);

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Writable, multi-bank colour palette for sprite and background pixels. Maps an INDEX_W-bit pixel index in a selectable bank to 12-bit RGB through a 2-stage registered pipeline. Adds a transparent-index flag and a frame-timed hit-flash override. Sits between the sprite ROM/compositor and the VGA colour outputs, replacing fixed single-table palettes.

## Interface
- INDEX_W, 4: pixel index width; each bank holds 2**INDEX_W entries.
- NUM_BANKS, 4: number of palettes; bank select width BANK_W = max(1, clog2(NUM_BANKS)).
- TRANSPARENT_IDX, 0: index value reported as transparent.
- FLASH_FRAMES, 8: frame ticks a hit flash lasts (≥1).
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- px_valid  in  1  lookup request this cycle.
- px_bank  in  BANK_W  palette bank for the lookup.
- px_index  in  INDEX_W  pixel colour index.
- wr_en  in  1  palette write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  12  {R,G,B}, 4 bits each.
- flash_start  in  1  one-cycle pulse starting a hit flash.
- frame_tick  in  1  one-cycle pulse per video frame.
- out_valid  out  1  output pixel valid.
- out_transparent  out  1  output pixel is transparent.
- red, green, blue  out  4 each  output colour.
- flash_active  out  1  flash override in effect.

## Operation
- Storage: NUM_BANKS × 2**INDEX_W × 12-bit register file; Reset clears every entry to 12'h000.
- Write: on a rising edge with wr_en=1, entry [wr_bank][wr_index] ← wr_rgb. wr_bank ≥ NUM_BANKS is ignored (no entry changes). Writes never stall lookups.
- Stage 1 (edge N): register px_valid, px_bank, px_index.
- Stage 2 (edge N+1): read table using stage-1 registers; register outputs:
  - out_valid ← stage-1 valid.
  - stage-1 bank ≥ NUM_BANKS: rgb ← 12'h000, out_transparent ← 1.
  - stage-1 index == TRANSPARENT_IDX: rgb ← 12'h000, out_transparent ← 1.
  - else if flash counter ≠ 0: rgb ← 12'hFFF, out_transparent ← 0.
  - else rgb ← table entry, out_transparent ← 0.
  - When stage-1 valid = 0: out_valid ← 0, out_transparent ← 0, rgb ← 12'h000.
- Flash counter, width clog2(FLASH_FRAMES+1):
  - flash_start=1: counter ← FLASH_FRAMES (reload, even mid-flash; wins over a simultaneous frame_tick).
  - else frame_tick=1 and counter ≠ 0: counter ← counter − 1.
  - flash_active = (counter ≠ 0), driven from the register.
- States: IDLE (counter=0) → FLASH on flash_start; FLASH → IDLE when tick decrements counter 1→0.

## Timing
- Reset values: out_valid 0, out_transparent 0, red/green/blue 0, flash_active 0, stage-1 registers 0, table all 0.
- Lookup latency: request sampled at edge N produces outputs after edge N+1 (2 edges); one lookup per cycle, fully pipelined, no back-pressure.
- Write/read ordering: a write at edge ≤ N is visible to a lookup sampled at edge N; a write at edge N+1 to the same entry is not (old value output).
- Flash applied at edge N+1 using counter value before that edge.
- Reset mid-stream: in-flight lookups are discarded; out_valid low from the first cycle Reset is high until one cycle after the first valid request post-reset.

## Test plan
- Reset then write bank 1 index 5 = 12'hD65; lookup (1,5) -> two edges later out_valid=1, {red,green,blue}={D,6,5}, out_transparent=0.
- Back-to-back lookups (0,3),(1,5),(0,0) on consecutive cycles -> consecutive outputs entry(0,3), 12'hD65, then transparent=1 with rgb 0.
- Write (2,7)=12'hABC on the same edge a lookup (2,7) is in stage 1 -> output old value 12'h000; lookup next cycle -> 12'hABC.
- flash_start then lookup (1,5) -> rgb 12'hFFF, flash_active=1; after 8 frame_ticks -> flash_active=0, rgb back to 12'hD65; transparent index stays transparent throughout.
- flash_start coincident with frame_tick at counter 3 -> counter 8, not 7; flash lasts 8 further ticks.
- Lookup with bank ≥ NUM_BANKS (NUM_BANKS=3, bank 3) -> out_transparent=1, rgb 0; write to bank 3 changes no entry; assert Reset mid-stream -> all outputs 0 immediately.
